// File: rtl/switch_allocator_rr_pkg.sv
// Shared definitions for the round-robin switch allocator.
// Holds the default port count, the "no port" code, the per-output FSM state type,
// and helpers that convert between port indices and select codes.
// Select codes: 0 = none, k = port k-1.
package switch_allocator_rr_pkg;

    localparam int NPORT_DEFAULT = 3;
    localparam int CODE_NONE     = 0;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } out_state_t;

    // Width of a select code able to name every port plus "none".
    function automatic int code_width(input int nport);
        return $clog2(nport + 1);
    endfunction

    // Width of a plain port index (at least one bit).
    function automatic int idx_width(input int nport);
        return (nport > 1) ? $clog2(nport) : 1;
    endfunction

    function automatic int idx_to_code(input int idx);
        return idx + 1;
    endfunction

endpackage

// File: rtl/switch_allocator_rr_if.sv
// Request/grant bundle between the routing logic and the switch allocator.
//   en         allocation enable
//   req_dir    per input i, slice [i*DW+:DW]: target output code (0 = none)
//   req_last   per input: current flit is packet tail
//   fail       per input: port failed, requests ignored
//   out_ready  per output: downstream can accept a new packet
//   sel_out    per output j, slice [j*DW+:DW]: granted source code (0 = idle)
//   gnt        per input: input currently owns an output
// master drives requests, slave (the allocator) drives selects and grants.
interface switch_allocator_rr_if
    import switch_allocator_rr_pkg::*;
#(
    parameter int NPORT = NPORT_DEFAULT,
    parameter int DW    = code_width(NPORT)
);
    logic                en;
    logic [NPORT*DW-1:0] req_dir;
    logic [NPORT-1:0]    req_last;
    logic [NPORT-1:0]    fail;
    logic [NPORT-1:0]    out_ready;
    logic [NPORT*DW-1:0] sel_out;
    logic [NPORT-1:0]    gnt;

    modport master (
        output en, req_dir, req_last, fail, out_ready,
        input  sel_out, gnt
    );

    modport slave (
        input  en, req_dir, req_last, fail, out_ready,
        output sel_out, gnt
    );
endinterface

// File: rtl/switch_allocator_rr_arbiter.sv
// Rotating-priority arbiter for one output.
//   req     candidate inputs
//   ptr     index of the highest-priority input this round
//   onehot  one-hot winner
//   idx     winner index
//   valid   at least one candidate present
module rr_arbiter #(
    parameter int NPORT = 3,
    parameter int PW    = 2
) (
    input  logic [NPORT-1:0] req,
    input  logic [PW-1:0]    ptr,
    output logic [NPORT-1:0] onehot,
    output logic [PW-1:0]    idx,
    output logic             valid
);

    // First pass looks only at inputs at or above ptr; the second pass covers
    // the wrapped-around range, so together they scan ptr, ptr+1, ... , ptr-1.
    always_comb begin
        onehot = '0;
        idx    = '0;
        valid  = 1'b0;
        for (int i = 0; i < NPORT; i++) begin
            if (!valid && req[i] && (i >= int'(ptr))) begin
                valid     = 1'b1;
                onehot[i] = 1'b1;
                idx       = PW'(i);
            end
        end
        for (int i = 0; i < NPORT; i++) begin
            if (!valid && req[i]) begin
                valid     = 1'b1;
                onehot[i] = 1'b1;
                idx       = PW'(i);
            end
        end
    end

endmodule

// File: rtl/switch_allocator_rr.sv
// Switch allocator: turns per-input routing requests into registered select codes
// for NPORT output selectors, with round-robin arbitration per output, packet locking
// until tail, fail masking and back-pressure checked at grant time.
//   clk    clock, rising edge
//   rst_n  asynchronous reset, active-high (1 = reset)
//   bus    slave side of switch_allocator_rr_if (requests in, sel_out/gnt out)
module switch_allocator_rr
    import switch_allocator_rr_pkg::*;
#(
    parameter int NPORT = NPORT_DEFAULT,
    parameter int DW    = code_width(NPORT)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    switch_allocator_rr_if.slave  bus
);

    localparam int PW = idx_width(NPORT);

    out_state_t       state_q [NPORT];
    out_state_t       state_d [NPORT];
    logic [PW-1:0]    owner_q [NPORT];
    logic [PW-1:0]    owner_d [NPORT];
    logic [PW-1:0]    ptr_q   [NPORT];
    logic [PW-1:0]    ptr_d   [NPORT];
    logic [DW-1:0]    sel_q   [NPORT];
    logic [DW-1:0]    sel_d   [NPORT];
    logic [NPORT-1:0] gnt_q;
    logic [NPORT-1:0] gnt_d;

    logic [NPORT-1:0] dir_hit    [NPORT];
    logic [NPORT-1:0] cand       [NPORT];
    logic [NPORT-1:0] arb_onehot [NPORT];
    logic [PW-1:0]    arb_idx    [NPORT];
    logic             arb_vld    [NPORT];
    logic             release_req [NPORT];

    // dir_hit[j][i]: input i is aiming at output j. Codes above NPORT match no
    // output and so behave as "no request".
    always_comb begin
        dir_hit = '{default: '0};
        cand    = '{default: '0};
        for (int j = 0; j < NPORT; j++) begin
            for (int i = 0; i < NPORT; i++) begin
                dir_hit[j][i] = (bus.req_dir[i*DW +: DW] == DW'(idx_to_code(j)));
                cand[j][i]    = dir_hit[j][i] && !bus.fail[i];
            end
        end
    end

    // Owner lets go on tail, on failure, or when it stops pointing at this output.
    always_comb begin
        for (int j = 0; j < NPORT; j++) begin
            release_req[j] = bus.req_last[owner_q[j]] || bus.fail[owner_q[j]] ||
                             !dir_hit[j][owner_q[j]];
        end
    end

    for (genvar j = 0; j < NPORT; j++) begin : g_out
        rr_arbiter #(
            .NPORT (NPORT),
            .PW    (PW)
        ) u_arb (
            .req    (cand[j]),
            .ptr    (ptr_q[j]),
            .onehot (arb_onehot[j]),
            .idx    (arb_idx[j]),
            .valid  (arb_vld[j])
        );
        assign bus.sel_out[j*DW +: DW] = sel_q[j];
    end

    assign bus.gnt = gnt_q;

    // Releases are applied before grants so an input that hops from one output
    // to another in the same cycle ends up with its grant bit set. An output
    // that releases is BUSY this cycle, so it cannot re-grant until next cycle.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        gnt_d   = gnt_q;
        if (bus.en) begin
            for (int j = 0; j < NPORT; j++) begin
                if (state_q[j] == ST_BUSY && release_req[j]) begin
                    state_d[j]          = ST_IDLE;
                    sel_d[j]            = DW'(CODE_NONE);
                    gnt_d[owner_q[j]]   = 1'b0;
                    ptr_d[j]            = (owner_q[j] == PW'(NPORT - 1)) ? '0
                                                                        : owner_q[j] + PW'(1);
                end
            end
            for (int j = 0; j < NPORT; j++) begin
                if (state_q[j] == ST_IDLE && arb_vld[j] && bus.out_ready[j]) begin
                    state_d[j] = ST_BUSY;
                    owner_d[j] = arb_idx[j];
                    sel_d[j]   = DW'(idx_to_code(int'(arb_idx[j])));
                    gnt_d      = gnt_d | arb_onehot[j];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            for (int j = 0; j < NPORT; j++) begin
                state_q[j] <= ST_IDLE;
                owner_q[j] <= '0;
                ptr_q[j]   <= '0;
                sel_q[j]   <= '0;
            end
            gnt_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            gnt_q   <= gnt_d;
        end
    end

endmodule

// File: tb/tb_switch_allocator_rr.sv
// Bench for switch_allocator_rr at NPORT=3: directed scenarios followed by
// randomized traffic, all checked against an owner/pointer reference model.
module tb_switch_allocator_rr;
    import switch_allocator_rr_pkg::*;

    localparam int N  = 3;
    localparam int DW = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    switch_allocator_rr_if #(.NPORT(N), .DW(DW)) bus ();

    switch_allocator_rr #(.NPORT(N), .DW(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: which input owns each output (-1 = free) and the
    // round-robin starting point of each output.
    int m_owner [N];
    int m_ptr   [N];

    function automatic int dir_of(input int i);
        return int'(bus.req_dir[i*DW +: DW]);
    endfunction

    task automatic model_reset();
        for (int j = 0; j < N; j++) begin
            m_owner[j] = -1;
            m_ptr[j]   = 0;
        end
    endtask

    task automatic model_step();
        int nxt [N];
        int s;
        int i;
        if (rst_n) begin
            model_reset();
            return;
        end
        if (!bus.en) return;
        nxt = m_owner;
        for (int j = 0; j < N; j++) begin
            if (m_owner[j] >= 0) begin
                s = m_owner[j];
                if (bus.req_last[s] || bus.fail[s] || dir_of(s) != j + 1) begin
                    nxt[j]   = -1;
                    m_ptr[j] = (s + 1) % N;
                end
            end else if (bus.out_ready[j]) begin
                for (int k = 0; k < N; k++) begin
                    i = (m_ptr[j] + k) % N;
                    if (nxt[j] < 0 && dir_of(i) == j + 1 && !bus.fail[i]) nxt[j] = i;
                end
            end
        end
        m_owner = nxt;
    endtask

    function automatic logic [N*DW-1:0] exp_sel();
        logic [N*DW-1:0] v;
        v = '0;
        for (int j = 0; j < N; j++)
            if (m_owner[j] >= 0) v[j*DW +: DW] = DW'(m_owner[j] + 1);
        return v;
    endfunction

    function automatic logic [N-1:0] exp_gnt();
        logic [N-1:0] v;
        v = '0;
        for (int j = 0; j < N; j++)
            if (m_owner[j] >= 0) v[m_owner[j]] = 1'b1;
        return v;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_model(input string tag);
        check_eq({tag, " sel_out"}, 32'(bus.sel_out), 32'(exp_sel()));
        check_eq({tag, " gnt"},     32'(bus.gnt),     32'(exp_gnt()));
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_model(tag);
    endtask

    task automatic set_dir(input int d0, input int d1, input int d2);
        bus.req_dir = {DW'(d2), DW'(d1), DW'(d0)};
    endtask

    int seq [8] = '{1, 0, 2, 0, 3, 0, 1, 0};

    initial begin
        bus.en        = 1'b0;
        bus.req_dir   = '0;
        bus.req_last  = '0;
        bus.fail      = '0;
        bus.out_ready = '0;
        model_reset();

        // Reset state
        repeat (2) @(negedge clk);
        check_eq("reset sel_out", 32'(bus.sel_out), 32'(0));
        check_eq("reset gnt",     32'(bus.gnt),     32'(0));
        rst_n         = 1'b0;
        bus.en        = 1'b1;
        bus.out_ready = '1;
        step("idle");

        // No conflict: in0->out1, in1->out2, in2->out0
        set_dir(2, 3, 1);
        step("noconf");
        check_eq("noconf sel const", 32'(bus.sel_out), 32'(6'b10_01_11));
        check_eq("noconf gnt const", 32'(bus.gnt),     32'(3'b111));
        repeat (3) step("noconf hold");

        // Asynchronous reset mid-packet
        rst_n = 1'b1;
        model_reset();
        #1;
        check_eq("async rst sel_out", 32'(bus.sel_out), 32'(0));
        check_eq("async rst gnt",     32'(bus.gnt),     32'(0));
        step("in reset");
        rst_n = 1'b0;
        set_dir(0, 0, 0);
        step("post reset");
        check_eq("no stale gnt", 32'(bus.gnt), 32'(0));

        // Conflict on out0, tail every packet
        set_dir(1, 1, 1);
        bus.req_last = '1;
        for (int k = 0; k < 8; k++) begin
            step("conflict");
            check_eq("conflict seq", 32'(bus.sel_out[1:0]), 32'(seq[k]));
        end
        set_dir(0, 0, 0);
        bus.req_last = '0;
        repeat (2) step("drain");

        // Lock: in1 owns out2 across 5 body flits, in0 waits
        set_dir(0, 3, 0);
        step("lock grant");
        set_dir(3, 3, 0);
        for (int k = 0; k < 5; k++) begin
            step("lock body");
            check_eq("lock held", 32'(bus.sel_out[5:4]), 32'(2));
        end
        bus.req_last[1] = 1'b1;
        step("lock tail");
        check_eq("lock gap", 32'(bus.sel_out[5:4]), 32'(0));
        bus.req_last = '0;
        step("lock next");
        check_eq("lock next owner", 32'(bus.sel_out[5:4]), 32'(1));
        set_dir(0, 0, 0);
        repeat (2) step("drain");

        // Fail abort: in2 owns out1 then fails
        set_dir(0, 0, 2);
        step("fail grant");
        check_eq("fail owner", 32'(bus.sel_out[3:2]), 32'(3));
        bus.fail = 3'b100;
        step("fail abort");
        check_eq("fail sel", 32'(bus.sel_out[3:2]), 32'(0));
        check_eq("fail gnt2", 32'(bus.gnt[2]), 32'(0));
        bus.fail = '0;
        set_dir(2, 0, 2);
        step("fail ptr");
        check_eq("fail ptr wraps to in0", 32'(bus.sel_out[3:2]), 32'(1));
        set_dir(0, 0, 0);
        repeat (2) step("drain");

        // Back-pressure and enable
        bus.out_ready = 3'b110;
        set_dir(1, 0, 0);
        repeat (2) begin
            step("bp hold");
            check_eq("bp no grant", 32'(bus.sel_out[1:0]), 32'(0));
        end
        bus.out_ready = '1;
        step("bp grant");
        check_eq("bp granted", 32'(bus.sel_out[1:0]), 32'(1));
        bus.en       = 1'b0;
        bus.req_last = 3'b001;
        repeat (3) begin
            step("en frozen");
            check_eq("en frozen sel", 32'(bus.sel_out[1:0]), 32'(1));
        end
        bus.en = 1'b1;
        step("en release");
        check_eq("en released", 32'(bus.sel_out[1:0]), 32'(0));
        bus.req_last = '0;
        set_dir(0, 0, 0);
        step("drain");

        // Randomized traffic
        for (int k = 0; k < 400; k++) begin
            bus.req_dir   = 6'($urandom);
            bus.req_last  = 3'($urandom) & 3'($urandom);
            bus.fail      = ($urandom_range(0, 9) == 0) ? 3'($urandom) : 3'b000;
            bus.out_ready = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b111;
            bus.en        = ($urandom_range(0, 7) != 0);
            rst_n         = ($urandom_range(0, 99) == 0);
            step("random");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
